// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Steps the select of an external 4:1 true/complement mux through
//   channels 0..3. Each channel is held for DWELL cycles. The mux outputs are
//   captured on the last cycle of each dwell. The four captured bits are
//   published as one word at frame end. A sticky error flag records any
//   capture where y == ybar.
// Parameters
//   DWELL  : cycles per channel, 2..255 (the first DWELL-1 cycles are settle time)
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   start  : frame request, honoured only while idle
//   cont   : 1 = continuous frames, 0 = single frame (sampled at frame end)
//   y      : true output of the mux
//   ybar   : complemented output of the mux
//   sel    : mux channel select
//   busy   : high while scanning
//   done   : one-cycle pulse after each completed frame
//   sample : last completed frame, bit k = y captured on channel k
//   err    : sticky true/complement consistency error
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       y,
   input  logic       ybar,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] sample,
   output logic       err
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   localparam logic [7:0] LAST = 8'(DWELL - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [1:0] sel_n;
   logic [2:0] shadow, shadow_n;
   logic [3:0] sample_n;
   logic       done_n;
   logic       err_n;
   logic       capture;

   assign busy    = (state == SCAN);
   assign capture = (state == SCAN) && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         sel    <= '0;
         shadow <= '0;
         sample <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         sel    <= sel_n;
         shadow <= shadow_n;
         sample <= sample_n;
         done   <= done_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sel_n    = sel;
      shadow_n = shadow;
      sample_n = sample;
      done_n   = 1'b0;
      err_n    = err;

      case (state)
         IDLE: begin
            if (start) begin
               state_n  = SCAN;
               cnt_n    = '0;
               sel_n    = '0;
               shadow_n = '0;
               err_n    = 1'b0;
            end
         end

         SCAN: begin
            cnt_n = cnt + 8'd1;
            if (capture) begin
               cnt_n = '0;
               sel_n = sel + 2'd1;
               if (y == ybar)
                  err_n = 1'b1;
               // Channel 3 never lands in the shadow: it goes straight into sample.
               case (sel)
                  2'd0:    shadow_n[0] = y;
                  2'd1:    shadow_n[1] = y;
                  2'd2:    shadow_n[2] = y;
                  default: ;
               endcase
               if (sel == 2'd3) begin
                  sample_n = {y, shadow};
                  done_n   = 1'b1;
                  if (cont)
                     shadow_n = '0;
                  else
                     state_n = IDLE;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
//   Drives two scanners (DWELL=4 and DWELL=2) from shared control inputs.
//   Each scanner has its own modelled 4:1 mux: y = mux_in[sel], ybar = ~y
//   unless force_eq ties them. A frame-position model predicts every output
//   on every cycle. Directed sequences add literal cycle/value expectations.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic [3:0] mux_in = 4'b0000;
   logic       force_eq = 1'b0;

   logic [1:0] sel4, sel2;
   logic       busy4, busy2, done4, done2, err4, err2;
   logic [3:0] sample4, sample2;
   logic       y4, yb4, y2, yb2;

   assign y4  = mux_in[sel4];
   assign yb4 = force_eq ? y4 : ~y4;
   assign y2  = mux_in[sel2];
   assign yb2 = force_eq ? y2 : ~y2;

   always #5 clk = ~clk;

   mux_scan_ctrl #(.DWELL(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .y(y4), .ybar(yb4),
      .sel(sel4), .busy(busy4), .done(done4), .sample(sample4), .err(err4)
   );

   mux_scan_ctrl #(.DWELL(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .y(y2), .ybar(yb2),
      .sel(sel2), .busy(busy2), .done(done2), .sample(sample2), .err(err2)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int t0 = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Behavioural model: position inside the frame (0..4*D-1) decides
   // the channel (pos / D) and whether this cycle is a capture (pos % D == D-1).
   int         dw[2] = '{4, 2};
   bit         m_act[2];
   int         m_pos[2];
   logic [3:0] m_bits[2];
   logic [3:0] m_sample[2];
   bit         m_err[2];
   bit         m_done[2];

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         logic yy, yyb;
         int   ch;
         yy  = (i == 0) ? y4 : y2;
         yyb = (i == 0) ? yb4 : yb2;
         m_done[i] = 1'b0;
         if (rst) begin
            m_act[i] = 1'b0; m_pos[i] = 0; m_bits[i] = 4'b0;
            m_sample[i] = 4'b0; m_err[i] = 1'b0;
         end else if (!m_act[i]) begin
            if (start) begin
               m_act[i] = 1'b1; m_pos[i] = 0; m_bits[i] = 4'b0; m_err[i] = 1'b0;
            end
         end else begin
            ch = m_pos[i] / dw[i];
            if (m_pos[i] % dw[i] == dw[i] - 1) begin
               m_bits[i][ch] = yy;
               if (yy == yyb) m_err[i] = 1'b1;
            end
            if (m_pos[i] == 4 * dw[i] - 1) begin
               m_sample[i] = m_bits[i];
               m_done[i]   = 1'b1;
               m_bits[i]   = 4'b0;
               m_pos[i]    = 0;
               m_act[i]    = cont;
            end else begin
               m_pos[i]++;
            end
         end
      end
      if (rst) chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int es;
            es = m_act[i] ? m_pos[i] / dw[i] : 0;
            chk(i == 0 ? "sel4" : "sel2", int'(i == 0 ? sel4 : sel2), es);
            chk(i == 0 ? "busy4" : "busy2", int'(i == 0 ? busy4 : busy2), int'(m_act[i]));
            chk(i == 0 ? "done4" : "done2", int'(i == 0 ? done4 : done2), int'(m_done[i]));
            chk(i == 0 ? "sample4" : "sample2", int'(i == 0 ? sample4 : sample2), int'(m_sample[i]));
            chk(i == 0 ? "err4" : "err2", int'(i == 0 ? err4 : err2), int'(m_err[i]));
         end
      end
   end

   task automatic upto(input int n);
      while (cyc < t0 + n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic settle();
      start = 1'b0;
      cont = 1'b0;
      force_eq = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sel", int'(sel4), 0);
      chk("rst_sample", int'(sample4), 0);
      chk("rst_busy", int'(busy4), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single frame, mux = 1010
      mux_in = 4'b1010;
      pulse_start();
      upto(5);  chk("single_sel_ch1", int'(sel4), 1);
      upto(9);  chk("single_d2_done", int'(done2), 1);
                chk("single_d2_sample", int'(sample2), 4'b1010);
      upto(16); chk("single_pre_done", int'(done4), 0);
                chk("single_sel_ch3", int'(sel4), 3);
      upto(17); chk("single_done", int'(done4), 1);
                chk("single_sample", int'(sample4), 4'b1010);
                chk("single_busy_low", int'(busy4), 0);
                chk("single_err", int'(err4), 0);
      upto(18); chk("single_done_once", int'(done4), 0);
      settle();

      // Continuous: 0110 then 1001 changed during frame 2 settle
      mux_in = 4'b0110;
      cont = 1'b1;
      pulse_start();
      upto(17); chk("cont_done1", int'(done4), 1);
                chk("cont_sample1", int'(sample4), 4'b0110);
      upto(18); mux_in = 4'b1001;
      upto(33); chk("cont_done2", int'(done4), 1);
                chk("cont_sample2", int'(sample4), 4'b1001);
      upto(40); cont = 1'b0;
      upto(48); chk("cont_busy_f3", int'(busy4), 1);
      upto(49); chk("cont_done3", int'(done4), 1);
                chk("cont_busy_end", int'(busy4), 0);
      upto(50); chk("cont_idle", int'(busy4), 0);
      settle();

      // Consistency fault on channel 2 capture (cycle 12)
      mux_in = 4'b0101;
      pulse_start();
      upto(11); chk("fault_err_pre", int'(err4), 0);
      upto(12); force_eq = 1'b1;
      upto(13); force_eq = 1'b0;
                chk("fault_err_set", int'(err4), 1);
      upto(17); chk("fault_done", int'(done4), 1);
                chk("fault_err_sticky", int'(err4), 1);
                chk("fault_sample", int'(sample4), 4'b0101);
      upto(20); chk("fault_err_hold", int'(err4), 1);
      pulse_start();
      chk("fault_err_clear", int'(err4), 0);
      settle();

      // Reset mid-frame in cycle 9
      mux_in = 4'b0011;
      pulse_start();
      upto(9);  rst = 1'b1;
      upto(10); rst = 1'b0;
                chk("abort_sel", int'(sel4), 0);
                chk("abort_busy", int'(busy4), 0);
                chk("abort_sample", int'(sample4), 0);
                chk("abort_err", int'(err4), 0);
      for (int k = 11; k <= 20; k++) begin
         upto(k); chk("abort_no_done", int'(done4), 0);
      end
      pulse_start();
      upto(17); chk("after_abort_done", int'(done4), 1);
                chk("after_abort_sample", int'(sample4), 4'b0011);
      settle();

      // start held high in single mode: back-to-back frames
      mux_in = 4'b1100;
      start = 1'b1;
      t0 = cyc;
      upto(9);  chk("held_d2_done1", int'(done2), 1);
      upto(16); chk("held_pre1", int'(done4), 0);
      upto(17); chk("held_done1", int'(done4), 1);
      upto(18); chk("held_post1", int'(done4), 0);
                chk("held_d2_done2", int'(done2), 1);
      upto(34); chk("held_done2", int'(done4), 1);
      upto(51); chk("held_done3", int'(done4), 1);
                chk("held_sample", int'(sample4), 4'b1100);
      settle();

      // Extra start pulses during SCAN
      mux_in = 4'b0111;
      pulse_start();
      upto(5);  start = 1'b1;
      upto(6);  start = 1'b0;
      upto(10); start = 1'b1;
      upto(11); start = 1'b0;
      upto(16); chk("extra_pre", int'(done4), 0);
      upto(17); chk("extra_done", int'(done4), 1);
      upto(18); chk("extra_post", int'(done4), 0);
      settle();

      // Randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         start    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) cont = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) mux_in = 4'($urandom);
         rst      = ($urandom_range(0, 199) == 0);
         force_eq = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      settle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
